// File: rtl/axi_pkg.sv
// AXI4 encodings and FSM state types shared by the burst RAM slave.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Only full-word INCR bursts are serviced; anything else is answered with SLVERR.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != AXI_SIZE_4B) || (burst != AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_burst_ram_if.sv
// AXI4 write/read channel bundle between the CPU-side master and the burst RAM.
interface axi_burst_ram_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] axi_awid;
    logic [31:0]     axi_awaddr;
    logic [7:0]      axi_awlen;
    logic [2:0]      axi_awsize;
    logic [1:0]      axi_awburst;
    logic            axi_awvalid;
    logic            axi_awready;
    logic [31:0]     axi_wdata;
    logic [3:0]      axi_wstrb;
    logic            axi_wlast;
    logic            axi_wvalid;
    logic            axi_wready;
    logic [ID_W-1:0] axi_bid;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid;
    logic            axi_bready;
    logic [ID_W-1:0] axi_arid;
    logic [31:0]     axi_araddr;
    logic [7:0]      axi_arlen;
    logic [2:0]      axi_arsize;
    logic [1:0]      axi_arburst;
    logic            axi_arvalid;
    logic            axi_arready;
    logic [ID_W-1:0] axi_rid;
    logic [31:0]     axi_rdata;
    logic [1:0]      axi_rresp;
    logic            axi_rlast;
    logic            axi_rvalid;
    logic            axi_rready;

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready
    );

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready
    );
endinterface

// File: rtl/bram_dp_be.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port (read-before-write).
module bram_dp_be #(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave word RAM with INCR bursts; independent write and read FSMs share a dual-port RAM.
module axi_burst_ram
    import axi_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    ID_W       = 4,
    parameter string INIT_FILE  = ""
) (
    input logic             clk,
    input logic             rst,
    axi_burst_ram_if.slave  axi
);
    wr_state_e             w_state_q, w_state_d;
    logic [ID_W-1:0]       w_id_q, w_id_d;
    logic [DEPTH_LOG2-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [8:0]            w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;

    rd_state_e             r_state_q, r_state_d;
    logic [ID_W-1:0]       r_id_q, r_id_d;
    logic [DEPTH_LOG2-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [8:0]            r_cnt_q, r_cnt_d;
    logic                  r_err_q, r_err_d;

    logic                  ram_we, ram_re;
    logic [DEPTH_LOG2-1:0] ram_raddr;
    logic [31:0]           ram_rdata;
    logic                  awready, wready, bvalid, arready, rvalid, rlast;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi.axi_awaddr[31:DEPTH_LOG2+2], axi.axi_awaddr[1:0],
                                axi.axi_araddr[31:DEPTH_LOG2+2], axi.axi_araddr[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        ram_we    = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready = 1'b1;
                if (axi.axi_awvalid) begin
                    w_id_d    = axi.axi_awid;
                    w_addr_d  = axi.axi_awaddr[DEPTH_LOG2+1:2];
                    w_len_d   = axi.axi_awlen;
                    w_cnt_d   = '0;
                    w_err_d   = burst_err(axi.axi_awsize, axi.axi_awburst);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (axi.axi_wvalid) begin
                    // Excess beats are swallowed; the counter saturates rather than wrapping back into range.
                    ram_we   = !w_err_q && (w_cnt_q <= {1'b0, w_len_q});
                    w_addr_d = w_addr_q + 1'b1;
                    if (w_cnt_q != '1) w_cnt_d = w_cnt_q + 9'd1;
                    if (axi.axi_wlast) begin
                        if (w_cnt_q != {1'b0, w_len_q}) w_err_d = 1'b1;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (axi.axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        ram_re    = 1'b0;
        ram_raddr = r_addr_q + 1'b1;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready   = 1'b1;
                ram_raddr = axi.axi_araddr[DEPTH_LOG2+1:2];
                if (axi.axi_arvalid) begin
                    ram_re    = 1'b1;
                    r_id_d    = axi.axi_arid;
                    r_addr_d  = axi.axi_araddr[DEPTH_LOG2+1:2];
                    r_len_d   = axi.axi_arlen;
                    r_cnt_d   = '0;
                    r_err_d   = burst_err(axi.axi_arsize, axi.axi_arburst);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_cnt_q == {1'b0, r_len_q});
                // Prefetch the next word on the accepting edge; the RAM output register holds during stalls.
                if (axi.axi_rready) begin
                    if (rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        ram_re   = 1'b1;
                        r_addr_d = r_addr_q + 1'b1;
                        r_cnt_d  = r_cnt_q + 9'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
        end
    end

    bram_dp_be #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(w_addr_q),
        .wdata(axi.axi_wdata),
        .wstrb(axi.axi_wstrb),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

    assign axi.axi_awready = awready;
    assign axi.axi_wready  = wready;
    assign axi.axi_bvalid  = bvalid;
    assign axi.axi_bid     = w_id_q;
    assign axi.axi_bresp   = (w_state_q == W_RESP && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign axi.axi_arready = arready;
    assign axi.axi_rvalid  = rvalid;
    assign axi.axi_rlast   = rlast;
    assign axi.axi_rid     = r_id_q;
    assign axi.axi_rdata   = (r_state_q == R_DATA && !r_err_q) ? ram_rdata : '0;
    assign axi.axi_rresp   = (r_state_q == R_DATA && r_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
endmodule

// File: tb/tb_axi_burst_ram.sv
// Self-checking bench for axi_burst_ram against a word-array model of the AXI burst rules.
module tb_axi_burst_ram;
    import axi_pkg::*;

    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;
    localparam int IDW   = 4;
    localparam int LIMIT = 600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_burst_ram_if #(.ID_W(IDW)) axi ();

    axi_burst_ram #(.DEPTH_LOG2(DL), .ID_W(IDW), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .axi(axi)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] model [DEPTH];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [1:0] exp_wresp(input logic [2:0] sz, input logic [1:0] bu, input int len, input int nb);
        return (sz != 3'b010 || bu != 2'b01 || nb != len + 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] sz,
                             input logic [1:0] bu, input logic [IDW-1:0] id, input int nb,
                             input logic [31:0] dq[$], input logic [3:0] sq[$],
                             output logic [1:0] bresp, output logic [IDW-1:0] bid);
        int n;
        @(negedge clk);
        axi.axi_awaddr = addr; axi.axi_awlen = len; axi.axi_awsize = sz;
        axi.axi_awburst = bu; axi.axi_awid = id; axi.axi_awvalid = 1'b1;
        n = 0;
        while (!axi.axi_awready && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) begin errors++; checks++; $display("FAIL aw_timeout awready=0 required=1"); end
        @(negedge clk);
        axi.axi_awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            axi.axi_wdata = dq[i]; axi.axi_wstrb = sq[i];
            axi.axi_wlast = (i == nb - 1); axi.axi_wvalid = 1'b1;
            n = 0;
            while (!axi.axi_wready && n < LIMIT) begin @(negedge clk); n++; end
            if (n >= LIMIT) begin errors++; checks++; $display("FAIL w_timeout wready=0 required=1"); end
            @(negedge clk);
        end
        axi.axi_wvalid = 1'b0; axi.axi_wlast = 1'b0; axi.axi_bready = 1'b1;
        n = 0;
        while (!axi.axi_bvalid && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) begin errors++; checks++; $display("FAIL b_timeout bvalid=0 required=1"); end
        bresp = axi.axi_bresp; bid = axi.axi_bid;
        @(negedge clk);
        axi.axi_bready = 1'b0;
        if (sz == 3'b010 && bu == 2'b01)
            for (int i = 0; i < nb && i <= int'(len); i++)
                model[(int'(addr[DL+1:2]) + i) % DEPTH] = merge(model[(int'(addr[DL+1:2]) + i) % DEPTH], dq[i], sq[i]);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic [IDW-1:0] id,
                            input int stall_beat, input int stall_cyc,
                            output logic [31:0] dq[$], output logic [1:0] rq[$], output logic lq[$],
                            output logic [IDW-1:0] rid, output bit lat_ok, output bit held_ok, output int cycles);
        int n, beat;
        logic [34:0] snap;
        dq = {}; rq = {}; lq = {};
        @(negedge clk);
        axi.axi_araddr = addr; axi.axi_arlen = len; axi.axi_arsize = sz;
        axi.axi_arburst = bu; axi.axi_arid = id; axi.axi_arvalid = 1'b1; axi.axi_rready = 1'b0;
        n = 0;
        while (!axi.axi_arready && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) begin errors++; checks++; $display("FAIL ar_timeout arready=0 required=1"); end
        lat_ok = !axi.axi_rvalid;
        @(negedge clk);
        axi.axi_arvalid = 1'b0;
        lat_ok = lat_ok && axi.axi_rvalid;
        held_ok = 1'b1; beat = 0; n = 0; cycles = 0;
        while (beat < int'(len) + 1 && n < LIMIT) begin
            if (beat == stall_beat && stall_cyc > 0) begin
                axi.axi_rready = 1'b0;
                snap = {axi.axi_rdata, axi.axi_rresp, axi.axi_rlast};
                repeat (stall_cyc) begin
                    @(negedge clk);
                    if ({axi.axi_rdata, axi.axi_rresp, axi.axi_rlast} !== snap || !axi.axi_rvalid) held_ok = 1'b0;
                end
                stall_cyc = 0;
            end
            axi.axi_rready = 1'b1;
            if (axi.axi_rvalid) begin
                dq.push_back(axi.axi_rdata); rq.push_back(axi.axi_rresp);
                lq.push_back(axi.axi_rlast); rid = axi.axi_rid; beat++;
            end
            @(negedge clk); n++; cycles++;
        end
        axi.axi_rready = 1'b0;
        if (n >= LIMIT) begin errors++; checks++; $display("FAIL r_timeout beats=%0d required=%0d", beat, int'(len) + 1); end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (axi.axi_awready !== 1'b1) begin errors++; $display("FAIL rst_awready got=%b exp=1", axi.axi_awready); end
        checks++; if (axi.axi_arready !== 1'b1) begin errors++; $display("FAIL rst_arready got=%b exp=1", axi.axi_arready); end
        checks++; if ({axi.axi_wready, axi.axi_bvalid, axi.axi_rvalid, axi.axi_rlast} !== 4'b0)
            begin errors++; $display("FAIL rst_valids got=%b exp=0000", {axi.axi_wready, axi.axi_bvalid, axi.axi_rvalid, axi.axi_rlast}); end
        checks++; if ({axi.axi_rdata, axi.axi_bresp, axi.axi_rresp, axi.axi_bid, axi.axi_rid} !== '0)
            begin errors++; $display("FAIL rst_data got rdata=%h bresp=%b rresp=%b bid=%h rid=%h exp=0",
                axi.axi_rdata, axi.axi_bresp, axi.axi_rresp, axi.axi_bid, axi.axi_rid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] d[$]; logic [1:0] r[$]; logic l[$]; logic [1:0] br; logic [IDW-1:0] bid, rid;
        bit lat, held; int cyc;
        axi_write(32'h10, 8'd0, 3'b010, AXI_BURST_INCR, 4'h3, 1, '{32'hDEADBEEF}, '{4'hF}, br, bid);
        checks++; if (br !== 2'b00) begin errors++; $display("FAIL single_bresp got=%b exp=00", br); end
        checks++; if (bid !== 4'h3) begin errors++; $display("FAIL single_bid got=%h exp=3", bid); end
        axi_read(32'h10, 8'd0, 3'b010, AXI_BURST_INCR, 4'h9, -1, 0, d, r, l, rid, lat, held, cyc);
        checks++; if (d.size() != 1 || d[0] !== 32'hDEADBEEF || r[0] !== 2'b00 || l[0] !== 1'b1)
            begin errors++; $display("FAIL single_read got n=%0d data=%h resp=%b last=%b exp 1/deadbeef/00/1", d.size(), d[0], r[0], l[0]); end
        checks++; if (!lat) begin errors++; $display("FAIL single_latency rvalid not exactly 1 cycle after AR"); end
        checks++; if (rid !== 4'h9) begin errors++; $display("FAIL single_rid got=%h exp=9", rid); end
    endtask

    task automatic test_burst_stall();
        logic [31:0] d[$]; logic [1:0] r[$]; logic l[$]; logic [1:0] br; logic [IDW-1:0] bid, rid;
        bit lat, held; int cyc;
        axi_write(32'h0, 8'd4, 3'b010, AXI_BURST_INCR, 4'h5, 5, '{1, 2, 3, 4, 5}, '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF}, br, bid);
        checks++; if (br !== 2'b00) begin errors++; $display("FAIL burst_bresp got=%b exp=00", br); end
        axi_read(32'h0, 8'd4, 3'b010, AXI_BURST_INCR, 4'h5, 2, 3, d, r, l, rid, lat, held, cyc);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (d.size() != 5 || d[i] !== 32'(i + 1) || l[i] !== (i == 4))
                begin errors++; $display("FAIL burst_beat%0d got=%h last=%b exp=%h last=%b", i, d[i], l[i], i + 1, i == 4); end
        end
        checks++; if (!held) begin errors++; $display("FAIL burst_stall_hold outputs changed while rready=0"); end
    endtask

    task automatic test_strobe();
        logic [31:0] d[$]; logic [1:0] r[$]; logic l[$]; logic [1:0] br; logic [IDW-1:0] bid, rid;
        bit lat, held; int cyc;
        axi_write(32'h40, 8'd0, 3'b010, AXI_BURST_INCR, 4'h1, 1, '{32'hFFFFFFFF}, '{4'hF}, br, bid);
        axi_write(32'h40, 8'd0, 3'b010, AXI_BURST_INCR, 4'h1, 1, '{32'h12345678}, '{4'b0101}, br, bid);
        axi_read(32'h40, 8'd0, 3'b010, AXI_BURST_INCR, 4'h1, -1, 0, d, r, l, rid, lat, held, cyc);
        checks++; if (d[0] !== 32'hFF34FF78) begin errors++; $display("FAIL strobe_merge got=%h exp=ff34ff78", d[0]); end
    endtask

    task automatic test_illegal();
        logic [31:0] d[$]; logic [1:0] r[$]; logic l[$]; logic [1:0] br; logic [IDW-1:0] bid, rid;
        bit lat, held; int cyc;
        axi_write(32'h80, 8'd0, 3'b010, AXI_BURST_INCR, 4'h2, 1, '{32'hA5A5A5A5}, '{4'hF}, br, bid);
        axi_write(32'h80, 8'd0, 3'b100, AXI_BURST_INCR, 4'h2, 1, '{32'h0}, '{4'hF}, br, bid);
        checks++; if (br !== 2'b10) begin errors++; $display("FAIL illegal_size_bresp got=%b exp=10", br); end
        axi_write(32'h80, 8'd0, 3'b010, AXI_BURST_FIXED, 4'h2, 1, '{32'h1}, '{4'hF}, br, bid);
        checks++; if (br !== 2'b10) begin errors++; $display("FAIL illegal_burst_bresp got=%b exp=10", br); end
        axi_read(32'h80, 8'd0, 3'b010, AXI_BURST_INCR, 4'h2, -1, 0, d, r, l, rid, lat, held, cyc);
        checks++; if (d[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL illegal_unchanged got=%h exp=a5a5a5a5", d[0]); end
        axi_read(32'h80, 8'd0, 3'b100, AXI_BURST_INCR, 4'h2, -1, 0, d, r, l, rid, lat, held, cyc);
        checks++; if (d[0] !== 32'h0 || r[0] !== 2'b10)
            begin errors++; $display("FAIL illegal_read got data=%h resp=%b exp 0/10", d[0], r[0]); end
    endtask

    task automatic test_wrap_early_last();
        logic [31:0] d[$]; logic [1:0] r[$]; logic l[$]; logic [1:0] br; logic [IDW-1:0] bid, rid;
        bit lat, held; int cyc;
        axi_write((DEPTH - 1) * 4, 8'd1, 3'b010, AXI_BURST_INCR, 4'h7, 2, '{32'hCAFE0001, 32'hCAFE0002}, '{4'hF, 4'hF}, br, bid);
        checks++; if (br !== 2'b00) begin errors++; $display("FAIL wrap_bresp got=%b exp=00", br); end
        axi_read(32'h0, 8'd0, 3'b010, AXI_BURST_INCR, 4'h7, -1, 0, d, r, l, rid, lat, held, cyc);
        checks++; if (d[0] !== 32'hCAFE0002) begin errors++; $display("FAIL wrap_word0 got=%h exp=cafe0002", d[0]); end
        axi_read((DEPTH - 1) * 4, 8'd1, 3'b010, AXI_BURST_INCR, 4'h7, -1, 0, d, r, l, rid, lat, held, cyc);
        checks++; if (d[0] !== 32'hCAFE0001 || d[1] !== 32'hCAFE0002)
            begin errors++; $display("FAIL wrap_read got=%h %h exp=cafe0001 cafe0002", d[0], d[1]); end
        axi_write(32'h200, 8'd3, 3'b010, AXI_BURST_INCR, 4'h8, 2, '{32'h11, 32'h22}, '{4'hF, 4'hF}, br, bid);
        checks++; if (br !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp got=%b exp=10", br); end
    endtask

    task automatic test_random();
        logic [31:0] d[$]; logic [1:0] r[$]; logic l[$]; logic [1:0] br; logic [IDW-1:0] bid, rid;
        logic [31:0] wd[$]; logic [3:0] ws[$]; bit lat, held; int cyc, len, nb; logic [31:0] a; logic [2:0] sz;
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(0, 7);
            nb  = ($urandom_range(0, 5) == 0) ? len + 1 + $urandom_range(0, 2) : len + 1;
            a   = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
            sz  = ($urandom_range(0, 6) == 0) ? 3'b001 : 3'b010;
            wd = {}; ws = {};
            for (int i = 0; i < nb; i++) begin wd.push_back($urandom); ws.push_back(4'($urandom)); end
            axi_write(a, 8'(len), sz, AXI_BURST_INCR, 4'(t), nb, wd, ws, br, bid);
            checks++; if (br !== exp_wresp(sz, AXI_BURST_INCR, len, nb) || bid !== 4'(t))
                begin errors++; $display("FAIL rand%0d_bresp got=%b/%h exp=%b/%h", t, br, bid, exp_wresp(sz, AXI_BURST_INCR, len, nb), 4'(t)); end
            axi_read(a, 8'(len), 3'b010, AXI_BURST_INCR, 4'(t), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                     d, r, l, rid, lat, held, cyc);
            for (int i = 0; i <= len; i++) begin
                checks++;
                if (d.size() != len + 1 || d[i] !== model[(int'(a[DL+1:2]) + i) % DEPTH] || r[i] !== 2'b00 || l[i] !== (i == len))
                    begin errors++; $display("FAIL rand%0d_beat%0d got=%h last=%b exp=%h last=%b", t, i, d[i], l[i],
                        model[(int'(a[DL+1:2]) + i) % DEPTH], i == len); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d[$]; logic [1:0] r[$]; logic l[$]; logic [1:0] br; logic [IDW-1:0] bid, rid;
        logic [31:0] wd[$]; logic [3:0] ws[$]; bit lat, held; int cyc, bad;
        wd = {}; ws = {};
        for (int i = 0; i < 256; i++) begin wd.push_back(32'h5000_0000 + 32'(i)); ws.push_back(4'hF); end
        axi_write(32'h800, 8'd255, 3'b010, AXI_BURST_INCR, 4'hA, 256, wd, ws, br, bid);
        checks++; if (br !== 2'b00) begin errors++; $display("FAIL len255_bresp got=%b exp=00", br); end
        axi_read(32'h800, 8'd255, 3'b010, AXI_BURST_INCR, 4'hA, -1, 0, d, r, l, rid, lat, held, cyc);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (d.size() != 256 || d[i] !== 32'h5000_0000 + 32'(i) || l[i] !== (i == 255)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL len255_data bad_beats=%0d exp=0", bad); end
        checks++; if (cyc != 256) begin errors++; $display("FAIL back_to_back cycles=%0d exp=256", cyc); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d[$]; logic [1:0] r[$]; logic l[$]; logic [IDW-1:0] rid;
        bit lat, held; int cyc, beat, n;
        @(negedge clk);
        axi.axi_araddr = 32'h800; axi.axi_arlen = 8'd7; axi.axi_arsize = 3'b010;
        axi.axi_arburst = AXI_BURST_INCR; axi.axi_arid = 4'h4; axi.axi_arvalid = 1'b1;
        @(negedge clk);
        axi.axi_arvalid = 1'b0; axi.axi_rready = 1'b1;
        beat = 0; n = 0;
        while (beat < 2 && n < LIMIT) begin if (axi.axi_rvalid) beat++; @(negedge clk); n++; end
        checks++; if (!axi.axi_rvalid) begin errors++; $display("FAIL midrst_beat3 rvalid=0 exp=1"); end
        #2 rst = 1'b1;
        #1;
        checks++; if (axi.axi_rvalid !== 1'b0 || axi.axi_arready !== 1'b1 || axi.axi_rlast !== 1'b0)
            begin errors++; $display("FAIL midrst_outputs rvalid=%b arready=%b rlast=%b exp=0/1/0", axi.axi_rvalid, axi.axi_arready, axi.axi_rlast); end
        axi.axi_rready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        axi_read(32'h800, 8'd7, 3'b010, AXI_BURST_INCR, 4'h4, -1, 0, d, r, l, rid, lat, held, cyc);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (d[i] !== model[512 + i]) begin errors++; $display("FAIL midrst_intact%0d got=%h exp=%h", i, d[i], model[512 + i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst = 1'b1;
        axi.axi_awid = '0; axi.axi_awaddr = '0; axi.axi_awlen = '0; axi.axi_awsize = '0;
        axi.axi_awburst = '0; axi.axi_awvalid = 1'b0; axi.axi_wdata = '0; axi.axi_wstrb = '0;
        axi.axi_wlast = 1'b0; axi.axi_wvalid = 1'b0; axi.axi_bready = 1'b0;
        axi.axi_arid = '0; axi.axi_araddr = '0; axi.axi_arlen = '0; axi.axi_arsize = '0;
        axi.axi_arburst = '0; axi.axi_arvalid = 1'b0; axi.axi_rready = 1'b0;
        test_reset();
        test_single();
        test_burst_stall();
        test_strobe();
        test_illegal();
        test_wrap_early_last();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
